// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: accepts WORD_W-bit words over valid/ready and shifts CHAIN_LEN bits
// LSB-first onto ccff_head. Optional CRC-16-CCITT of the shifted stream under `CCFF_LOADER_CRC_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc_out,
  output logic [1:0]        state_dbg_o
);

  // Handshake: a word transfers on a rising prog_clk edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in LOAD, and cfg_data must be held stable while cfg_valid waits.

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W = $clog2(WORD_W + 1);
  localparam logic [BL_W-1:0] BL_FULL = BL_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_shift_d;
  logic              ready_q, head_q, shift_q, busy_q, done_q;

  always_comb begin
    sreg_shift_d = sreg_q >> 1;
    bits_left_d  = bits_left_q - 1'b1;
    word_cnt_d   = word_cnt_q - 1'b1;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      bits_left_q <= '0;
      word_cnt_q  <= '0;
      sreg_q      <= '0;
      ready_q     <= 1'b0;
      head_q      <= 1'b0;
      shift_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      // Abort overrides any same-cycle start or word acceptance.
      state_q <= IDLE;
      ready_q <= 1'b0;
      head_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= LOAD;
            bits_left_q <= BL_FULL;
            ready_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_valid && ready_q) begin
            state_q    <= SHIFT;
            sreg_q     <= cfg_data;
            head_q     <= cfg_data[0];
            shift_q    <= 1'b1;
            ready_q    <= 1'b0;
            word_cnt_q <= WC_FULL;
          end
        end
        SHIFT: begin
          bits_left_q <= bits_left_d;
          word_cnt_q  <= word_cnt_d;
          sreg_q      <= sreg_shift_d;
          // Chain end takes priority so a partial last word drops its upper bits.
          if (bits_left_d == '0) begin
            state_q <= DONE;
            shift_q <= 1'b0;
            head_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (word_cnt_d == '0) begin
            state_q <= LOAD;
            shift_q <= 1'b0;
            head_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            head_q <= sreg_shift_d[0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready     = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign state_dbg_o   = state_q;

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;

  always_comb begin
    crc_fb = crc_q[15] ^ head_q;
    crc_d  = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  // Each bit is folded in on the edge that ends its shift cycle; the value holds after done.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      crc_q <= 16'hFFFF;
    end else if (state_q == IDLE && start && !abort) begin
      crc_q <= 16'hFFFF;
    end else if (shift_q) begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 16'hFFFF;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (CHAIN_LEN 8 and 10, WORD_W 8), table-driven loads
// plus hand sequences for stall, abort, reset mid-load and ignored start.
module tb_ccff_chain_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start_s[2], abort_s[2], valid_s[2];
  logic        ready_s[2], head_s[2], sen_s[2], busy_s[2], done_s[2];
  logic [7:0]  data_s[2];
  logic [15:0] crc_s[2];
  logic [1:0]  st_s[2];

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk(clk), .pReset(rst), .start(start_s[0]), .abort(abort_s[0]),
    .cfg_data(data_s[0]), .cfg_valid(valid_s[0]), .cfg_ready(ready_s[0]),
    .ccff_head(head_s[0]), .ccff_shift_en(sen_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .crc_out(crc_s[0]), .state_dbg_o(st_s[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) dut10 (
    .prog_clk(clk), .pReset(rst), .start(start_s[1]), .abort(abort_s[1]),
    .cfg_data(data_s[1]), .cfg_valid(valid_s[1]), .cfg_ready(ready_s[1]),
    .ccff_head(head_s[1]), .ccff_shift_en(sen_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .crc_out(crc_s[1]), .state_dbg_o(st_s[1])
  );

  // ---------------- scoreboard state ----------------
  logic [0:0]  exp_q[$];
  logic [0:0]  mon_b;
  logic [15:0] crc_ref;
  int          n_vec = 0;
  int          n_err = 0;
  int          shift_cnt[2];
  int          done_cnt[2];
  int          active = 0;
  int          mdl_left = 0;
  logic        mon_en = 1'b0;

  typedef struct {
    int         d;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         exp_n;
  } vec_t;
  vec_t tbl[5];

  function automatic int chain_len(input int d);
    return (d == 0) ? 8 : 10;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] exp_crc();
`ifdef CCFF_LOADER_CRC_EN
    return crc_ref;
`else
    return 16'hFFFF;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pop expected bit on every shift cycle ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (sen_s[d] === 1'b1) begin
          shift_cnt[d]++;
          if (d != active || exp_q.size() == 0) begin
            chk("shift_unexpected", 32'd1, 32'd0);
          end else begin
            mon_b = exp_q.pop_front();
            chk("head_bit", {31'd0, head_s[d]}, {31'd0, mon_b});
            crc_ref = crc_step(crc_ref, mon_b[0]);
          end
        end else begin
          chk("head_idle_zero", {31'd0, head_s[d]}, 32'd0);
        end
        if (done_s[d] === 1'b1) done_cnt[d]++;
      end
    end
  end

  // ---------------- driver tasks (all start/end at #1 after a rising edge) ----------------
  task automatic do_start(input int d);
    active   = d;
    crc_ref  = 16'hFFFF;
    mdl_left = chain_len(d);
    start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    chk("ready_after_start", {31'd0, ready_s[d]}, 32'd1);
  endtask

  task automatic send_word(input int d, input logic [7:0] w);
    int c;
    c = 0;
    data_s[d]  = w;
    valid_s[d] = 1'b1;
    while (ready_s[d] !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("ready_wait", {31'd0, ready_s[d]}, 32'd1);
    for (int i = 0; i < 8 && mdl_left > 0; i++) begin
      exp_q.push_back(w[i]);
      mdl_left--;
    end
    @(posedge clk); #1;
    valid_s[d] = 1'b0;
    chk("shift_after_accept", {31'd0, sen_s[d]}, 32'd1);
  endtask

  task automatic wait_done(input int d);
    int c;
    c = 0;
    while (done_s[d] !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_seen", {31'd0, done_s[d]}, 32'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done_s[d]}, 32'd0);
    chk("busy_after_done", {31'd0, busy_s[d]}, 32'd0);
    chk("state_idle", {30'd0, st_s[d]}, 32'd0);
  endtask

  task automatic run_vec(input int d, input int nw, input logic [7:0] w0,
                         input logic [7:0] w1, input int exp_n);
    int s0, dn0;
    s0  = shift_cnt[d];
    dn0 = done_cnt[d];
    do_start(d);
    send_word(d, w0);
    if (nw > 1) send_word(d, w1);
    wait_done(d);
    chk("shift_count", shift_cnt[d] - s0, exp_n);
    chk("done_count", done_cnt[d] - dn0, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("crc", {16'd0, crc_s[d]}, {16'd0, exp_crc()});
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; abort_s[d] = 1'b0; valid_s[d] = 1'b0; data_s[d] = 8'h00;
      shift_cnt[d] = 0; done_cnt[d] = 0;
    end
    crc_ref = 16'hFFFF;

    tbl[0] = '{0, 1, 8'hA5, 8'h00, 8};
    tbl[1] = '{1, 2, 8'hFF, 8'hFE, 10};
    tbl[2] = '{0, 1, 8'h00, 8'h00, 8};
    tbl[3] = '{1, 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 10};
    tbl[4] = '{0, 1, 8'($urandom_range(0, 255)), 8'h00, 8};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, ready_s[d]}, 32'd0);
      chk("rst_head", {31'd0, head_s[d]}, 32'd0);
      chk("rst_shift_en", {31'd0, sen_s[d]}, 32'd0);
      chk("rst_busy", {31'd0, busy_s[d]}, 32'd0);
      chk("rst_done", {31'd0, done_s[d]}, 32'd0);
      chk("rst_crc", {16'd0, crc_s[d]}, 32'h0000FFFF);
    end

    // Table-driven full loads
    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i].d, tbl[i].nw, tbl[i].w0, tbl[i].w1, tbl[i].exp_n);
      if (i == 2) begin
`ifdef CCFF_LOADER_CRC_EN
        chk("crc_zero_byte", {16'd0, crc_s[0]}, 32'h0000E1F0);
`else
        chk("crc_zero_byte", {16'd0, crc_s[0]}, 32'h0000FFFF);
`endif
      end
    end

    // Stall in LOAD for 5 cycles, then resume
    begin
      int s0;
      s0 = shift_cnt[1];
      do_start(1);
      for (int c = 0; c < 5; c++) begin
        chk("stall_shift_en", {31'd0, sen_s[1]}, 32'd0);
        chk("stall_busy", {31'd0, busy_s[1]}, 32'd1);
        @(posedge clk); #1;
      end
      send_word(1, 8'hC3);
      send_word(1, 8'h02);
      wait_done(1);
      chk("stall_shift_count", shift_cnt[1] - s0, 32'd10);
      chk("stall_queue_empty", exp_q.size(), 32'd0);
    end

    // Abort on the 3rd SHIFT cycle, then a full reload
    begin
      int dn0;
      dn0 = done_cnt[0];
      do_start(0);
      send_word(0, 8'h96);
      @(posedge clk); #1;
      @(posedge clk); #1;
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      exp_q.delete();
      chk("abort_busy", {31'd0, busy_s[0]}, 32'd0);
      chk("abort_shift_en", {31'd0, sen_s[0]}, 32'd0);
      chk("abort_ready", {31'd0, ready_s[0]}, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt[0] - dn0, 32'd0);
      run_vec(0, 1, 8'h3E, 8'h00, 8);
    end

    // Start while busy is ignored; start together with abort in IDLE is ignored
    begin
      int s0, dn0;
      s0  = shift_cnt[1];
      dn0 = done_cnt[1];
      do_start(1);
      send_word(1, 8'h5A);
      start_s[1] = 1'b1;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      send_word(1, 8'h3C);
      wait_done(1);
      chk("busy_start_shift_count", shift_cnt[1] - s0, 32'd10);
      chk("busy_start_done_count", done_cnt[1] - dn0, 32'd1);
      start_s[1] = 1'b1;
      abort_s[1] = 1'b1;
      @(posedge clk); #1;
      start_s[1] = 1'b0;
      abort_s[1] = 1'b0;
      chk("start_abort_busy", {31'd0, busy_s[1]}, 32'd0);
      chk("start_abort_ready", {31'd0, ready_s[1]}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("start_abort_no_shift", shift_cnt[1] - s0, 32'd10);
    end

    // Reset mid-load behaves as abort and clears crc_out
    begin
      int dn0;
      dn0 = done_cnt[0];
      do_start(0);
      send_word(0, 8'hF0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      crc_ref = 16'hFFFF;
      chk("rst_mid_busy", {31'd0, busy_s[0]}, 32'd0);
      chk("rst_mid_shift_en", {31'd0, sen_s[0]}, 32'd0);
      chk("rst_mid_crc", {16'd0, crc_s[0]}, 32'h0000FFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_no_done", done_cnt[0] - dn0, 32'd0);
      run_vec(0, 1, 8'h81, 8'h00, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
